cmd_assembler: RTL and testbench

- Sequences the SUMP instruction decoder.
- Collects bytes from the UART receiver into complete SUMP commands: a short command is a 1-byte opcode; a long command is an opcode plus 4 data bytes.
- Presents each complete command to the decoder with a valid/ready handshake.
- Sits between the UART RX and the instruction decoder, and drops partial commands on an inter-byte timeout.

---
 rtl/cmd_assembler.sv | 155 +++++++++++++++
 tb/tb_cmd_assembler.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/cmd_assembler.sv
// Assembles SUMP command bytes from the UART receiver into opcode/data words and
// hands them to the instruction decoder over a valid/ready handshake.
module cmd_assembler #(
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
    parameter int unsigned LONG_MSB       = 7
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        rx_stb_i,
    input  logic [7:0]  rx_dat_i,
    output logic        cmd_stb_o,
    input  logic        cmd_rdy_i,
    output logic [7:0]  opc_o,
    output logic [31:0] cmd_o,
    output logic        busy_o,
    output logic        tmo_o,
    output logic        ovf_o
);

    localparam int unsigned TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam bit TMO_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [TW-1:0] TCNT_LAST = (TIMEOUT_CYCLES > 0) ? TW'(TIMEOUT_CYCLES - 1) : {TW{1'b0}};
    localparam logic [TW-1:0] TCNT_MAX  = {TW{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_EMIT = 2'd2
    } state_t;

    state_t        state_r, state_nxt_s;
    logic [7:0]    opc_r, opc_nxt_s;
    logic [31:0]   cmd_r, cmd_nxt_s;
    logic [1:0]    idx_r, idx_nxt_s;
    logic [TW-1:0] tcnt_r, tcnt_nxt_s;
    logic          stb_r, stb_nxt_s;
    logic          busy_r, busy_nxt_s;
    logic          tmo_r, tmo_nxt_s;
    logic          ovf_r, ovf_nxt_s;

    // State and output registers; every output comes straight from a flop.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r <= ST_IDLE;
            opc_r   <= 8'h00;
            cmd_r   <= 32'h0000_0000;
            idx_r   <= 2'd0;
            tcnt_r  <= {TW{1'b0}};
            stb_r   <= 1'b0;
            busy_r  <= 1'b0;
            tmo_r   <= 1'b0;
            ovf_r   <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            opc_r   <= opc_nxt_s;
            cmd_r   <= cmd_nxt_s;
            idx_r   <= idx_nxt_s;
            tcnt_r  <= tcnt_nxt_s;
            stb_r   <= stb_nxt_s;
            busy_r  <= busy_nxt_s;
            tmo_r   <= tmo_nxt_s;
            ovf_r   <= ovf_nxt_s;
        end
    end

    // Next-state and next-output logic; pulses default low, everything else holds.
    always_comb begin
        state_nxt_s = state_r;
        opc_nxt_s   = opc_r;
        cmd_nxt_s   = cmd_r;
        idx_nxt_s   = idx_r;
        tcnt_nxt_s  = tcnt_r;
        stb_nxt_s   = stb_r;
        busy_nxt_s  = busy_r;
        tmo_nxt_s   = 1'b0;
        ovf_nxt_s   = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (rx_stb_i) begin
                    opc_nxt_s = rx_dat_i;
                    if (rx_dat_i[LONG_MSB]) begin
                        state_nxt_s = ST_DATA;
                        idx_nxt_s   = 2'd0;
                        tcnt_nxt_s  = {TW{1'b0}};
                        busy_nxt_s  = 1'b1;
                    end else begin
                        cmd_nxt_s   = 32'h0000_0000;
                        state_nxt_s = ST_EMIT;
                        stb_nxt_s   = 1'b1;
                    end
                end else begin
                    stb_nxt_s  = 1'b0;
                    busy_nxt_s = 1'b0;
                end
            end

            ST_DATA: begin
                // An arriving byte wins over a coincident terminal count.
                if (rx_stb_i) begin
                    cmd_nxt_s[{idx_r, 3'b000} +: 8] = rx_dat_i;
                    tcnt_nxt_s = {TW{1'b0}};
                    if (idx_r == 2'd3) begin
                        state_nxt_s = ST_EMIT;
                        idx_nxt_s   = 2'd0;
                        stb_nxt_s   = 1'b1;
                        busy_nxt_s  = 1'b0;
                    end else begin
                        idx_nxt_s = idx_r + 2'd1;
                    end
                end else if (TMO_EN && (tcnt_r == TCNT_LAST)) begin
                    state_nxt_s = ST_IDLE;
                    tcnt_nxt_s  = {TW{1'b0}};
                    idx_nxt_s   = 2'd0;
                    busy_nxt_s  = 1'b0;
                    tmo_nxt_s   = 1'b1;
                end else if (TMO_EN && (tcnt_r != TCNT_MAX)) begin
                    tcnt_nxt_s = tcnt_r + TW'(1'b1);
                end else begin
                    tcnt_nxt_s = tcnt_r;
                end
            end

            ST_EMIT: begin
                if (rx_stb_i) begin
                    ovf_nxt_s = 1'b1;
                end else begin
                    ovf_nxt_s = 1'b0;
                end
                if (cmd_rdy_i) begin
                    state_nxt_s = ST_IDLE;
                    stb_nxt_s   = 1'b0;
                end else begin
                    stb_nxt_s = 1'b1;
                end
            end

            default: begin
                state_nxt_s = ST_IDLE;
                stb_nxt_s   = 1'b0;
                busy_nxt_s  = 1'b0;
                idx_nxt_s   = 2'd0;
                tcnt_nxt_s  = {TW{1'b0}};
            end
        endcase
    end

    assign cmd_stb_o = stb_r;
    assign opc_o     = opc_r;
    assign cmd_o     = cmd_r;
    assign busy_o    = busy_r;
    assign tmo_o     = tmo_r;
    assign ovf_o     = ovf_r;

endmodule

// File: tb/tb_cmd_assembler.sv
// Directed-vector bench for cmd_assembler: short/long commands, backpressure,
// timeout and its race with a late byte, and reset in the middle of traffic.
module tb_cmd_assembler;

    logic        clk_s = 1'b0;
    logic        rst_s;
    logic        rx_stb_s;
    logic [7:0]  rx_dat_s;
    logic        cmd_stb_s;
    logic        cmd_rdy_s;
    logic [7:0]  opc_s;
    logic [31:0] cmd_s;
    logic        busy_s;
    logic        tmo_s;
    logic        ovf_s;

    int n_vec = 0;
    int n_err = 0;

    cmd_assembler #(.TIMEOUT_CYCLES(16), .LONG_MSB(7)) dut (
        .clk_i     (clk_s),
        .rst_i     (rst_s),
        .rx_stb_i  (rx_stb_s),
        .rx_dat_i  (rx_dat_s),
        .cmd_stb_o (cmd_stb_s),
        .cmd_rdy_i (cmd_rdy_s),
        .opc_o     (opc_s),
        .cmd_o     (cmd_s),
        .busy_o    (busy_s),
        .tmo_o     (tmo_s),
        .ovf_o     (ovf_s)
    );

    always #5 clk_s = ~clk_s;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are then read 1 ns after the edge.
    task automatic step();
        @(posedge clk_s);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        rx_stb_s = 1'b1;
        rx_dat_s = b;
        step();
        rx_stb_s = 1'b0;
        rx_dat_s = 8'h00;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".stb"},  {31'd0, cmd_stb_s}, 32'd0);
        chk({tag, ".opc"},  {24'd0, opc_s},     32'd0);
        chk({tag, ".cmd"},  cmd_s,              32'd0);
        chk({tag, ".busy"}, {31'd0, busy_s},    32'd0);
        chk({tag, ".tmo"},  {31'd0, tmo_s},     32'd0);
        chk({tag, ".ovf"},  {31'd0, ovf_s},     32'd0);
    endtask

    initial begin
        rst_s     = 1'b1;
        rx_stb_s  = 1'b0;
        rx_dat_s  = 8'h00;
        cmd_rdy_s = 1'b0;
        step();
        step();
        rst_s = 1'b0;
        chk_all_zero("reset");

        // Short command with decoder ready
        cmd_rdy_s = 1'b1;
        send(8'h00);
        chk("short.stb", {31'd0, cmd_stb_s}, 32'd1);
        chk("short.opc", {24'd0, opc_s}, 32'h00);
        chk("short.cmd", cmd_s, 32'h0000_0000);
        step();
        chk("short.stb_drop", {31'd0, cmd_stb_s}, 32'd0);

        // Long command, bytes spaced 3 cycles apart
        send(8'hC0);
        chk("long.busy0", {31'd0, busy_s}, 32'd1);
        begin
            logic [7:0] dat_v [4];
            dat_v[0] = 8'h78; dat_v[1] = 8'h56; dat_v[2] = 8'h34; dat_v[3] = 8'h12;
            for (int i = 0; i < 4; i++) begin
                step();
                step();
                chk("long.busy_gap", {31'd0, busy_s}, 32'd1);
                chk("long.stb_gap", {31'd0, cmd_stb_s}, 32'd0);
                send(dat_v[i]);
            end
        end
        chk("long.busy_end", {31'd0, busy_s}, 32'd0);
        chk("long.stb", {31'd0, cmd_stb_s}, 32'd1);
        chk("long.opc", {24'd0, opc_s}, 32'hC0);
        chk("long.cmd", cmd_s, 32'h1234_5678);
        step();
        chk("long.stb_drop", {31'd0, cmd_stb_s}, 32'd0);

        // Backpressure: stb held 10 cycles, byte 0x02 dropped at cycle 5
        cmd_rdy_s = 1'b0;
        send(8'h01);
        for (int i = 1; i <= 10; i++) begin
            chk("bp.stb_held", {31'd0, cmd_stb_s}, 32'd1);
            chk("bp.opc_held", {24'd0, opc_s}, 32'h01);
            if (i == 5) begin
                rx_stb_s = 1'b1;
                rx_dat_s = 8'h02;
            end
            cmd_rdy_s = (i == 10);
            step();
            rx_stb_s = 1'b0;
            chk("bp.ovf", {31'd0, ovf_s}, (i == 5) ? 32'd1 : 32'd0);
        end
        chk("bp.stb_done", {31'd0, cmd_stb_s}, 32'd0);
        chk("bp.opc_kept", {24'd0, opc_s}, 32'h01);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bp.no_phantom", {31'd0, cmd_stb_s}, 32'd0);
        end

        // Timeout: 0x80, 0xAA then silence
        cmd_rdy_s = 1'b1;
        send(8'h80);
        send(8'hAA);
        for (int k = 1; k <= 16; k++) begin
            step();
            chk("tmo.pulse", {31'd0, tmo_s}, (k == 16) ? 32'd1 : 32'd0);
            chk("tmo.no_stb", {31'd0, cmd_stb_s}, 32'd0);
        end
        chk("tmo.busy", {31'd0, busy_s}, 32'd0);
        chk("tmo.opc_kept", {24'd0, opc_s}, 32'h80);
        chk("tmo.cmd_kept", cmd_s, 32'h0000_00AA);
        step();
        chk("tmo.one_cycle", {31'd0, tmo_s}, 32'd0);
        send(8'h11);
        chk("tmo.next_stb", {31'd0, cmd_stb_s}, 32'd1);
        chk("tmo.next_opc", {24'd0, opc_s}, 32'h11);
        chk("tmo.next_cmd", cmd_s, 32'h0000_0000);
        step();

        // Timeout race: byte lands exactly on the terminal count
        send(8'h82);
        send(8'h01);
        for (int k = 1; k <= 15; k++) begin
            step();
            chk("race.idle_tmo", {31'd0, tmo_s}, 32'd0);
        end
        send(8'h02);
        chk("race.tmo", {31'd0, tmo_s}, 32'd0);
        chk("race.busy", {31'd0, busy_s}, 32'd1);
        send(8'h03);
        send(8'h04);
        chk("race.stb", {31'd0, cmd_stb_s}, 32'd1);
        chk("race.opc", {24'd0, opc_s}, 32'h82);
        chk("race.cmd", cmd_s, 32'h0403_0201);
        step();
        chk("race.stb_drop", {31'd0, cmd_stb_s}, 32'd0);

        // Reset one cycle after the 2nd data byte of a long command
        cmd_rdy_s = 1'b0;
        send(8'h81);
        send(8'hA1);
        send(8'hA2);
        step();
        rst_s = 1'b1;
        step();
        rst_s = 1'b0;
        chk_all_zero("rst_data");
        send(8'h02);
        chk("rst_data.stb", {31'd0, cmd_stb_s}, 32'd1);
        chk("rst_data.opc", {24'd0, opc_s}, 32'h02);
        chk("rst_data.cmd", cmd_s, 32'h0000_0000);

        // Reset while a command is being presented
        step();
        rst_s = 1'b1;
        step();
        rst_s = 1'b0;
        chk_all_zero("rst_emit");
        cmd_rdy_s = 1'b1;
        send(8'h02);
        chk("rst_emit.stb", {31'd0, cmd_stb_s}, 32'd1);
        chk("rst_emit.opc", {24'd0, opc_s}, 32'h02);
        step();
        chk("rst_emit.stb_drop", {31'd0, cmd_stb_s}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
